// File: rtl/micro_alarm_if.sv
`default_nettype none
// ============================================================================
// Module      : micro_alarm_if
// Description : Control/status bundle between a scheduler (master) and the
//               micro_alarm timer (slave).
//               master drives : cfg_valid, cfg_delay, cfg_period, cfg_periodic,
//                               cancel, irq_ack
//               slave drives  : cfg_ready, irq, busy, missed, fire_time
// Revision    : 1.0 - initial release
// ============================================================================
interface micro_alarm_if #(
  parameter int TIME_W = 32,
  parameter int MISS_W = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [TIME_W-1:0] cfg_delay;
  logic [TIME_W-1:0] cfg_period;
  logic              cfg_periodic;
  logic              cancel;
  logic              irq;
  logic              irq_ack;
  logic              busy;
  logic [MISS_W-1:0] missed;
  logic [TIME_W-1:0] fire_time;

  modport master (
    output cfg_valid, cfg_delay, cfg_period, cfg_periodic, cancel, irq_ack,
    input  cfg_ready, irq, busy, missed, fire_time
  );

  modport slave (
    input  cfg_valid, cfg_delay, cfg_period, cfg_periodic, cancel, irq_ack,
    output cfg_ready, irq, busy, missed, fire_time
  );
endinterface
`default_nettype wire

// File: rtl/micro_alarm.sv
`default_nettype none
// ============================================================================
// Module      : micro_alarm
// Description : Programmable one-shot / periodic alarm driven by the system
//               microsecond time-base. Raises a level irq at an absolute
//               deadline and holds it until acknowledged; wrap-safe across
//               the 2^TIME_W rollover of the time-base.
// Ports       : clk       - system clock (time-base domain)
//               reset     - asynchronous assert, active-low
//               timeMicro - current microsecond count
//               bus       - micro_alarm_if.slave (config handshake, cancel,
//                           irq/irq_ack, busy, missed, fire_time)
// Revision    : 1.0 - initial release
// ============================================================================
module micro_alarm #(
  parameter int TIME_W = 32,
  parameter int MISS_W = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [TIME_W-1:0] timeMicro,
  micro_alarm_if.slave           bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest forward distance the signed compare can resolve.
  localparam logic [TIME_W-1:0] c_delay_max = {1'b0, {(TIME_W-1){1'b1}}};

  state_t            state_q,     state_d;
  logic              irq_q,       irq_d;
  logic [MISS_W-1:0] missed_q,    missed_d;
  logic [TIME_W-1:0] fire_time_q, fire_time_d;
  logic [TIME_W-1:0] target_q,    target_d;
  logic [TIME_W-1:0] period_q,    period_d;
  logic              mode_q,      mode_d;

  logic              w_accept;
  logic              w_ack;
  logic              w_expired;
  logic [TIME_W-1:0] w_diff;
  logic [TIME_W-1:0] w_delay_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      irq_q       <= 1'b0;
      missed_q    <= '0;
      fire_time_q <= '0;
      target_q    <= '0;
      period_q    <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      missed_q    <= missed_d;
      fire_time_q <= fire_time_d;
      target_q    <= target_d;
      period_q    <= period_d;
      mode_q      <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    irq_d       = irq_q;
    missed_d    = missed_q;
    fire_time_d = fire_time_q;
    target_d    = target_q;
    period_d    = period_q;
    mode_d      = mode_q;

    w_accept  = bus.cfg_valid && (state_q != ST_DONE);
    w_ack     = bus.irq_ack && irq_q;
    // Sign of (now - target) decides expiry, so the test survives rollover.
    w_diff    = timeMicro - target_q;
    w_expired = (state_q == ST_ARMED) && !w_diff[TIME_W-1];
    w_delay_c = bus.cfg_delay[TIME_W-1] ? c_delay_max : bus.cfg_delay;

    // Acknowledge is applied first; cancel/accept/expiry below may override.
    if (w_ack) begin
      irq_d    = 1'b0;
      missed_d = '0;
      if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end

    if (bus.cancel) begin
      state_d  = ST_IDLE;
      irq_d    = 1'b0;
      missed_d = '0;
    end else if (w_accept) begin
      // A pending expiry of the old deadline is discarded here.
      target_d = timeMicro + w_delay_c;
      period_d = (bus.cfg_period == '0) ? TIME_W'(1) : bus.cfg_period;
      mode_d   = bus.cfg_periodic;
      state_d  = ST_ARMED;
    end else if (w_expired) begin
      irq_d       = 1'b1;
      fire_time_d = timeMicro;
      // With a concurrent ack, missed stays at the cleared value.
      if (irq_q && !w_ack && (missed_q != {MISS_W{1'b1}})) begin
        missed_d = missed_q + MISS_W'(1);
      end
      if (mode_q) begin
        // Advance from the old deadline, not from now, so the period never drifts.
        target_d = target_q + period_q;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  assign bus.cfg_ready = (state_q != ST_DONE);
  assign bus.busy      = (state_q == ST_ARMED);
  assign bus.irq       = irq_q;
  assign bus.missed    = missed_q;
  assign bus.fire_time = fire_time_q;

endmodule
`default_nettype wire

// File: tb/tb_micro_alarm.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_alarm
// Description : Directed self-checking bench for micro_alarm. The bench owns
//               the time-base value and advances it by one per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_alarm;

  localparam int TIME_W = 32;
  localparam int MISS_W = 8;

  logic              clk;
  logic              reset;
  logic [TIME_W-1:0] tm;

  int n_checks;
  int n_fail;

  micro_alarm_if #(.TIME_W(TIME_W), .MISS_W(MISS_W)) bus ();

  micro_alarm #(.TIME_W(TIME_W), .MISS_W(MISS_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .timeMicro (tm),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: the edge samples the current tm, then the time-base advances.
  task automatic step();
    @(posedge clk);
    #1;
    tm = tm + 1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm(input logic [TIME_W-1:0] dly, input logic [TIME_W-1:0] per,
                     input logic periodic);
    bus.cfg_valid    = 1'b1;
    bus.cfg_delay    = dly;
    bus.cfg_period   = per;
    bus.cfg_periodic = periodic;
    step();
    bus.cfg_valid    = 1'b0;
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1;
    step();
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    logic seen_irq;
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b0;
    tm               = '0;
    bus.cfg_valid    = 1'b0;
    bus.cfg_delay    = '0;
    bus.cfg_period   = '0;
    bus.cfg_periodic = 1'b0;
    bus.cancel       = 1'b0;
    bus.irq_ack      = 1'b0;

    // ---------------- reset values
    steps(2);
    check("rst_irq",       bus.irq, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_ready",     bus.cfg_ready, 1);
    check("rst_missed",    bus.missed, 0);
    check("rst_fire_time", bus.fire_time, 0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- one-shot at 1000 + 50
    @(posedge clk); #1;
    tm = 1000;
    arm(50, 0, 1'b0);
    check("os_busy", bus.busy, 1);
    steps(49);
    check("os_no_irq_early", bus.irq, 0);
    step();
    check("os_irq",       bus.irq, 1);
    check("os_fire_time", bus.fire_time, 1050);
    check("os_ready_0",   bus.cfg_ready, 0);
    check("os_busy_0",    bus.busy, 0);
    steps(2);
    ack();
    check("os_ack_irq",   bus.irq, 0);
    check("os_ack_ready", bus.cfg_ready, 1);
    check("os_ack_busy",  bus.busy, 0);

    // ---------------- rollover
    tm = 32'hFFFF_FFF0;
    arm(32'h20, 0, 1'b0);
    seen_irq = 1'b0;
    while (tm != 32'h10) begin
      if (bus.irq) seen_irq = 1'b1;
      step();
    end
    if (bus.irq) seen_irq = 1'b1;
    check("wrap_no_irq", seen_irq, 0);
    step();
    check("wrap_irq",       bus.irq, 1);
    check("wrap_fire_time", bus.fire_time, 32'h10);
    ack();

    // ---------------- periodic 100 + 10, period 25
    tm = 100;
    arm(10, 25, 1'b1);
    steps(10);
    check("per_first_irq",  bus.irq, 1);
    check("per_first_fire", bus.fire_time, 110);
    steps(75);
    check("per_missed3",  bus.missed, 3);
    check("per_fire185",  bus.fire_time, 185);
    steps(4);
    check("per_tm190", tm, 190);
    ack();
    check("per_ack_missed", bus.missed, 0);
    check("per_ack_irq",    bus.irq, 0);
    check("per_ack_busy",   bus.busy, 1);
    steps(20);
    check("per_next_irq",  bus.irq, 1);
    check("per_next_fire", bus.fire_time, 210);
    steps(25);
    check("per_missed1", bus.missed, 1);
    steps(24);
    ack();
    check("expack_irq",    bus.irq, 1);
    check("expack_missed", bus.missed, 0);
    check("expack_fire",   bus.fire_time, 260);
    check("expack_busy",   bus.busy, 1);

    // ---------------- cancel beats config
    bus.cancel    = 1'b1;
    bus.cfg_valid = 1'b1;
    step();
    bus.cancel    = 1'b0;
    bus.cfg_valid = 1'b0;
    check("cancel_busy",  bus.busy, 0);
    check("cancel_irq",   bus.irq, 0);
    check("cancel_ready", bus.cfg_ready, 1);
    check("cancel_fire",  bus.fire_time, 260);

    // ---------------- saturation of missed, period 0 treated as 1
    arm(0, 0, 1'b1);
    steps(300);
    check("sat_missed", bus.missed, 255);
    check("sat_irq",    bus.irq, 1);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("sat_cancel_missed", bus.missed, 0);

    // ---------------- delay clamp
    tm = 0;
    arm(32'h8000_0005, 0, 1'b0);
    tm = 32'h7FFF_FFFE;
    step();
    check("clamp_no_irq", bus.irq, 0);
    step();
    check("clamp_irq",  bus.irq, 1);
    check("clamp_fire", bus.fire_time, 32'h7FFF_FFFF);
    ack();

    // ---------------- async reset while armed with irq pending
    tm = 500;
    arm(0, 10, 1'b1);
    step();
    check("prerst_irq", bus.irq, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_irq",    bus.irq, 0);
    check("arst_busy",   bus.busy, 0);
    check("arst_ready",  bus.cfg_ready, 1);
    check("arst_missed", bus.missed, 0);
    check("arst_fire",   bus.fire_time, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_rst_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
